// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and types used by the write-back/register-file slice.
package legv8_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CNT_W     = 32;

  localparam logic [REG_IDX_W-1:0] REG_XZR = 5'd31;

  // Only X0..X30 have storage; XZR is synthesised as a constant zero.
  localparam int unsigned NUM_ARCH_REGS = 31;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  function automatic logic is_xzr(input reg_idx_t idx);
    return idx == REG_XZR;
  endfunction

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: memory load data versus ALU result.
module wb_mux #(
  parameter int unsigned W = 64
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in0,
  output logic [W-1:0] o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/wb_regfile.sv
// LEGv8 write-back stage and 2-read/1-write register file with XZR, same-cycle
// write-to-read bypass and a count of committed writes.
module wb_regfile
  import legv8_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    read_data,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic                 regWrite,
  input  logic                 memtoReg,
  input  logic [REG_IDX_W-1:0] read_reg1,
  input  logic [REG_IDX_W-1:0] read_reg2,
  output logic [DATA_W-1:0]    read_data1,
  output logic [DATA_W-1:0]    read_data2,
  output logic [DATA_W-1:0]    wb_data,
  output logic [CNT_W-1:0]     wb_count
);

  localparam int unsigned NUM_RD = 2;

  data_t    r_regs [NUM_ARCH_REGS];
  cnt_t     r_wb_count;

  data_t    w_wb_data;
  logic     w_wr_match;
  reg_idx_t w_rd_idx  [NUM_RD];
  data_t    w_rd_data [NUM_RD];

  wb_mux #(.W(DATA_W)) u_wb_mux (
    .i_sel (memtoReg),
    .i_in1 (read_data),
    .i_in0 (alu_result),
    .o_out (w_wb_data)
  );

  // Not gated by reset: the bypass must stay live while storage is clearing.
  assign w_wr_match = regWrite && !is_xzr(write_reg);

  assign w_rd_idx[0] = read_reg1;
  assign w_rd_idx[1] = read_reg2;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign w_rd_data[gi] = is_xzr(w_rd_idx[gi])                        ? '0 :
                           (w_wr_match && write_reg == w_rd_idx[gi])  ? w_wb_data :
                                                                        r_regs[w_rd_idx[gi]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_wr_match) begin
      r_regs[write_reg] <= w_wb_data;
      r_wb_count        <= r_wb_count + cnt_t'(1);
    end
  end

  assign read_data1 = w_rd_data[0];
  assign read_data2 = w_rd_data[1];
  assign wb_data    = w_wb_data;
  assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: write/read, bypass, XZR, reset priority, wrap.
module tb_wb_regfile;
  import legv8_pkg::*;

  logic                 clk;
  logic                 reset;
  logic [DATA_W-1:0]    read_data;
  logic [DATA_W-1:0]    alu_result;
  logic [REG_IDX_W-1:0] write_reg;
  logic                 regWrite;
  logic                 memtoReg;
  logic [REG_IDX_W-1:0] read_reg1;
  logic [REG_IDX_W-1:0] read_reg2;
  logic [DATA_W-1:0]    read_data1;
  logic [DATA_W-1:0]    read_data2;
  logic [DATA_W-1:0]    wb_data;
  logic [CNT_W-1:0]     wb_count;

  int pass_cnt  = 0;
  int check_cnt = 0;

  wb_regfile dut (
    .clock      (clk),
    .reset      (reset),
    .read_data  (read_data),
    .alu_result (alu_result),
    .write_reg  (write_reg),
    .regWrite   (regWrite),
    .memtoReg   (memtoReg),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wb_data    (wb_data),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-18s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; read_data = '0; alu_result = '0; write_reg = '0;
    regWrite = 1'b0; memtoReg = 1'b0; read_reg1 = '0; read_reg2 = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_count", 64'(wb_count), 64'd0);
    check("rst_x0", read_data1, 64'd0);
    check("rst_wbdata", wb_data, 64'd0);

    // Basic write then read
    regWrite = 1'b1; memtoReg = 1'b0; alu_result = 64'h1234; write_reg = 5'd5;
    step();
    regWrite = 1'b0; read_reg1 = 5'd5;
    #1;
    check("wr_rd_x5", read_data1, 64'h1234);
    check("wr_rd_count", 64'(wb_count), 64'd1);

    // Same-cycle bypass on both ports
    regWrite = 1'b1; memtoReg = 1'b1; read_data = 64'hDEAD_BEEF; write_reg = 5'd7;
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    #1;
    check("byp_rd1", read_data1, 64'hDEAD_BEEF);
    check("byp_rd2", read_data2, 64'hDEAD_BEEF);
    step();
    regWrite = 1'b0; memtoReg = 1'b0;
    #1;
    check("byp_stored", read_data1, 64'hDEAD_BEEF);
    check("byp_count", 64'(wb_count), 64'd2);

    // XZR write is discarded and reads as zero
    regWrite = 1'b1; alu_result = 64'hFFFF; write_reg = 5'd31; read_reg1 = 5'd31; read_reg2 = 5'd5;
    #1;
    check("xzr_same", read_data1, 64'd0);
    check("xzr_wbdata", wb_data, 64'hFFFF);
    step();
    regWrite = 1'b0;
    #1;
    check("xzr_after", read_data1, 64'd0);
    check("xzr_count", 64'(wb_count), 64'd2);
    check("xzr_x5_kept", read_data2, 64'h1234);

    // Disabled write leaves old X2
    regWrite = 1'b1; alu_result = 64'h22; write_reg = 5'd2;
    step();
    regWrite = 1'b0; alu_result = 64'h99; write_reg = 5'd2; read_reg1 = 5'd2;
    #1;
    check("dis_rd1", read_data1, 64'h22);
    check("dis_wbdata", wb_data, 64'h99);
    step();
    check("dis_after", read_data1, 64'h22);
    check("dis_count", 64'(wb_count), 64'd3);

    // Independent ports
    read_reg1 = 5'd5; read_reg2 = 5'd7;
    #1;
    check("two_rd1", read_data1, 64'h1234);
    check("two_rd2", read_data2, 64'hDEAD_BEEF);

    // Reset priority over a coincident write, bypass still live
    regWrite = 1'b1; alu_result = 64'hAA; write_reg = 5'd3;
    step();
    reset = 1'b1; regWrite = 1'b1; write_reg = 5'd4; alu_result = 64'h55;
    read_reg1 = 5'd4; read_reg2 = 5'd3;
    #1;
    check("rstp_bypass", read_data1, 64'h55);
    check("rstp_x3_pre", read_data2, 64'hAA);
    check("rstp_cnt_pre", 64'(wb_count), 64'd4);
    step();
    reset = 1'b0; regWrite = 1'b0;
    #1;
    check("rstp_x4", read_data1, 64'd0);
    check("rstp_x3", read_data2, 64'd0);
    check("rstp_count", 64'(wb_count), 64'd0);

    // First edge after reset commits normally
    regWrite = 1'b1; alu_result = 64'h77; write_reg = 5'd6;
    step();
    regWrite = 1'b0; read_reg1 = 5'd6;
    #1;
    check("post_rst_x6", read_data1, 64'h77);
    check("post_rst_cnt", 64'(wb_count), 64'd1);

    // Counter wrap from a preloaded all-ones value
    force dut.r_wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wb_count;
    #1;
    check("wrap_preload", 64'(wb_count), 64'h0000_0000_FFFF_FFFF);
    regWrite = 1'b1; alu_result = 64'h8; write_reg = 5'd8; read_reg2 = 5'd8;
    step();
    regWrite = 1'b0;
    #1;
    check("wrap_count", 64'(wb_count), 64'd0);
    check("wrap_x8", read_data2, 64'h8);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset, sampled at posedge clock.
REQ-003 SHALL have read_data  input  64  memory load data from the MEM/WB register.
REQ-004 SHALL have alu_result  input  64  ALU result from the MEM/WB register.
REQ-005 SHALL have write_reg  input  5  destination register index.
REQ-006 SHALL have regWrite  input  1  write-back enable.
REQ-007 SHALL have memtoReg  input  1  1 selects read_data and 0 selects alu_result.
REQ-008 SHALL have read_reg1  input  5  source index, port 1.
REQ-009 SHALL have read_reg2  input  5  source index, port 2.
REQ-010 SHALL have read_data1  output  64  port 1 operand.
REQ-011 SHALL have read_data2  output  64  port 2 operand.
REQ-012 SHALL have wb_data  output  64  selected write-back value, for EX forwarding.
REQ-013 SHALL have wb_count  output  32  count of committed register writes.

Function
REQ-014 SHALL hold 31 architectural 64-bit registers X0..X30; index 31 is XZR and SHALL have no storage.
REQ-015 SHALL drive wb_data combinationally as memtoReg ? read_data : alu_result, regardless of regWrite.
REQ-016 SHALL write wb_data into X[write_reg] at posedge clock when regWrite=1, reset=0 and write_reg!=31.
REQ-017 SHALL ignore a write to index 31 and leave all registers unchanged.
REQ-018 SHALL return 0 combinationally for any read of index 31.
REQ-019 SHALL bypass a same-cycle write: when regWrite=1, write_reg==read_regN and write_reg!=31, read_dataN SHALL equal wb_data in that cycle (write-before-read, zero extra latency).
REQ-020 SHALL otherwise return the stored X[read_regN] combinationally on read_dataN.
REQ-021 SHALL let both read ports address the same register simultaneously, each with identical bypass behaviour.
REQ-022 SHALL increment wb_count by 1 at each posedge where a write commits per REQ-016; suppressed writes to index 31 SHALL NOT count.
REQ-023 SHALL wrap wb_count from 32'hFFFF_FFFF to 0 with no saturation and no flag.
REQ-024 SHALL give X/Z-free outputs whenever all inputs are known.

Reset
REQ-025 SHALL clear X0..X30 and wb_count to 0 at a posedge with reset=1.
REQ-026 SHALL give reset priority over a coincident write: with reset=1 and regWrite=1, the write SHALL be discarded and the count SHALL NOT increment.
REQ-027 SHALL keep the bypass path active during reset, so read_dataN reflects wb_data when REQ-019 matches; stored state SHALL still clear.
REQ-028 SHALL resume normal writes on the first posedge after reset deasserts.

Structure
REQ-029 SHALL take REG_XZR (31), DATA_W (64), REG_IDX_W (5) and CNT_W (32) from the shared package legv8_pkg.
REQ-030 SHALL implement the REQ-015 select in one sub-module, wb_mux (2:1, DATA_W wide); storage, bypass and counter stay in wb_regfile.
REQ-031 SHALL contain no latches; the register array SHALL be written only in the single clocked process.

Verification
REQ-032 SHALL cover basic write and read: regWrite=1, memtoReg=0, alu_result=64'h1234, write_reg=5; next cycle read_reg1=5 -> read_data1=64'h1234 and wb_count=1.
REQ-033 SHALL cover the same-cycle bypass: regWrite=1, memtoReg=1, read_data=64'hDEAD_BEEF, write_reg=7, read_reg1=read_reg2=7 in the same cycle -> both read_data1 and read_data2 = 64'hDEAD_BEEF before the edge.
REQ-034 SHALL cover XZR: write 64'hFFFF to write_reg=31 -> read_reg1=31 gives 0 in the same cycle and after the edge, and wb_count is unchanged.
REQ-035 SHALL cover reset priority: X3=64'hAA; then reset=1 with regWrite=1, write_reg=4, alu_result=64'h55 -> after the edge X3=0, X4=0 and wb_count=0.
REQ-036 SHALL cover counter wrap: preload to 32'hFFFF_FFFF via 2^32-1 commits or a forced value, then commit one write -> wb_count=0.
REQ-037 SHALL cover the disabled write: regWrite=0, write_reg=2, alu_result=64'h99, read_reg1=2 -> read_data1 keeps the old X2 value and wb_data=64'h99.
